div_iter: RTL and testbench

Parametrised iterative restoring divider for the EX stage: the successor of the fixed 32-bit divider, serving DIV/DIVU. It generalises operand width and quotient bits retired per cycle (STEP) and latches operands and signs at start, so the operand buses may change during the operation. It adds an explicit divide-by-zero flag with defined results and a busy indicator. It sits beside the ALU and is driven by the EX stage's stall/annul logic through the existing start/ready handshake.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_step.sv | 27 ++
 rtl/div_iter.sv | 144 ++++++++++++++
 tb/tb_div_iter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared state encodings, handshake constants and parameter check
//            for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_t;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  function automatic bit div_params_ok(input int width, input int step);
    return ((step == 1) || (step == 2) || (step == 4)) &&
           (width > 1) && ((width % step) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division step (subtract, select,
//            shift the next dividend bit in and the quotient bit out).
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic [WIDTH-1:0] part_quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quot
);

  // part_quot carries the unconsumed dividend bits at its top end
  logic [WIDTH:0] w_trial;

  assign w_trial   = {part_rem, part_quot[WIDTH-1]} - {1'b0, divisor};
  assign next_rem  = w_trial[WIDTH] ? {part_rem[WIDTH-2:0], part_quot[WIDTH-1]}
                                    : w_trial[WIDTH-1:0];
  assign next_quot = {part_quot[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Iterative restoring divider, STEP quotient bits per cycle, with
//            divide-by-zero flag, annul and start/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic               busy_o
);

  localparam int c_iters = WIDTH / STEP;
  localparam int c_cnt_w = $clog2(c_iters + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_iters);

  if (!div_params_ok(WIDTH, STEP)) begin : g_bad_params
    $error("div_iter: STEP must be 1, 2 or 4 and must divide WIDTH");
  end

  div_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_signed;
  logic               r_sign1;
  logic               r_sign2;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_divisor;

  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [STEP:0][WIDTH-1:0] w_rem_chain;
  logic [STEP:0][WIDTH-1:0] w_quot_chain;

  assign w_mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  assign w_rem_chain[0]  = r_rem;
  assign w_quot_chain[0] = r_quot;

  for (genvar i = 0; i < STEP; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .part_rem  (w_rem_chain[i]),
      .part_quot (w_quot_chain[i]),
      .divisor   (r_divisor),
      .next_rem  (w_rem_chain[i+1]),
      .next_quot (w_quot_chain[i+1])
    );
  end

  assign busy_o = (r_state != DIV_FREE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= '0;
      r_signed   <= 1'b0;
      r_sign1    <= 1'b0;
      r_sign2    <= 1'b0;
      r_div_zero <= 1'b0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_divisor  <= '0;
      result_o   <= '0;
      ready_o    <= DIV_RESULT_NOT_READY;
      div_zero_o <= 1'b0;
    end else begin
      case (r_state)
        DIV_FREE: begin
          ready_o    <= DIV_RESULT_NOT_READY;
          result_o   <= '0;
          div_zero_o <= 1'b0;
          if (start_i == DIV_START && !annul_i) begin
            r_signed   <= signed_div_i;
            r_sign1    <= opdata1_i[WIDTH-1];
            r_sign2    <= opdata2_i[WIDTH-1];
            r_quot     <= w_mag1;
            r_divisor  <= w_mag2;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            // A zero divisor keeps the raw dividend as its remainder
            if (opdata2_i == '0) begin
              r_rem   <= opdata1_i;
              r_state <= DIV_BYZERO;
            end else begin
              r_rem   <= '0;
              r_state <= DIV_ON;
            end
          end
        end
        DIV_BYZERO: begin
          r_quot     <= '1;
          r_div_zero <= 1'b1;
          r_state    <= DIV_END;
        end
        DIV_ON: begin
          if (annul_i) begin
            r_cnt   <= '0;
            r_state <= DIV_FREE;
          end else if (r_cnt != c_last) begin
            r_rem  <= w_rem_chain[STEP];
            r_quot <= w_quot_chain[STEP];
            r_cnt  <= r_cnt + 1'b1;
          end else begin
            if (r_signed && (r_sign1 ^ r_sign2)) r_quot <= -r_quot;
            if (r_signed && r_sign1)             r_rem  <= -r_rem;
            r_cnt   <= '0;
            r_state <= DIV_END;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            ready_o    <= DIV_RESULT_NOT_READY;
            result_o   <= '0;
            div_zero_o <= 1'b0;
            r_state    <= DIV_FREE;
          end else begin
            ready_o    <= DIV_RESULT_READY;
            result_o   <= {r_rem, r_quot};
            div_zero_o <= r_div_zero;
          end
        end
        default: r_state <= DIV_FREE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Scoreboard bench for div_iter at WIDTH=32/STEP=1 and
//            WIDTH=16/STEP=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          lat;
    int          edge0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        start32 = 1'b0, sd32 = 1'b0, annul32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] res32;
  logic        rdy32, dz32, busy32;

  logic        start16 = 1'b0, sd16 = 1'b0, annul16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] res16;
  logic        rdy16, dz16, busy16;

  exp_t q32[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_iter #(.WIDTH(32), .STEP(1)) u_dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sd32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(rdy32),
    .div_zero_o(dz32), .busy_o(busy32)
  );

  div_iter #(.WIDTH(16), .STEP(4)) u_dut16 (
    .clk(clk), .rst(rst), .signed_div_i(sd16), .opdata1_i(a16), .opdata2_i(b16),
    .start_i(start16), .annul_i(annul16), .result_o(res16), .ready_o(rdy16),
    .div_zero_o(dz16), .busy_o(busy16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: compare each rising ready against the oldest expectation
  initial begin
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy32 && !prev) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready32: got ready with empty scoreboard");
        end else begin
          e = q32.pop_front();
          chk("result32", res32, e.res);
          chk("divzero32", {63'd0, dz32}, {63'd0, e.dz});
          chk("latency32", 64'(cyc - e.edge0), 64'(e.lat));
        end
      end
      prev = rdy32;
    end
  end

  initial begin
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy16 && !prev) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready16: got ready with empty scoreboard");
        end else begin
          e = q16.pop_front();
          chk("result16", {32'd0, res16}, e.res);
          chk("divzero16", {63'd0, dz16}, {63'd0, e.dz});
          chk("latency16", 64'(cyc - e.edge0), 64'(e.lat));
        end
      end
      prev = rdy16;
    end
  end

  // Called #1 after a rising edge; the next edge is the start-sample edge
  task automatic run(input bit is16, input bit sd, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp_res,
                     input bit exp_dz, input int lat, input bit mid);
    exp_t e;
    bit   got;
    e.res = exp_res; e.dz = exp_dz; e.lat = lat; e.edge0 = cyc + 1;
    if (is16) begin
      start16 = 1'b1; sd16 = sd; a16 = a[15:0]; b16 = b[15:0]; q16.push_back(e);
    end else begin
      start32 = 1'b1; sd32 = sd; a32 = a; b32 = b; q32.push_back(e);
    end
    @(posedge clk); #1;
    chk("busy_after_start", {63'd0, (is16 ? busy16 : busy32)}, 64'd1);
    if (mid) begin
      if (is16) begin a16 = 16'h1234; b16 = '0; sd16 = ~sd; end
      else begin a32 = 32'h12345678; b32 = '0; sd32 = ~sd; end
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      got = is16 ? rdy16 : rdy32;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready within 100 cycles expected ready");
    end
    @(posedge clk); #1;
    chk("ready_hold", {63'd0, (is16 ? rdy16 : rdy32)}, 64'd1);
    if (is16) start16 = 1'b0; else start32 = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", {63'd0, (is16 ? rdy16 : rdy32)}, 64'd0);
    chk("result_drop", is16 ? {32'd0, res16} : res32, 64'd0);
    chk("divzero_drop", {63'd0, (is16 ? dz16 : dz32)}, 64'd0);
    chk("busy_drop", {63'd0, (is16 ? busy16 : busy32)}, 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result32", res32, 64'd0);
    chk("reset_ready32", {63'd0, rdy32}, 64'd0);
    chk("reset_divzero32", {63'd0, dz32}, 64'd0);
    chk("reset_busy32", {63'd0, busy32}, 64'd0);
    chk("reset_busy16", {63'd0, busy16}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run(0, 0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 0, 34, 0);
    run(0, 1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 34, 1);
    run(0, 1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 0, 34, 0);
    run(0, 0, 32'd5, 32'd0, {32'h00000005, 32'hFFFFFFFF}, 1, 2, 0);
    run(0, 1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 0, 34, 0);
    run(0, 0, 32'hFFFFFFFF, 32'd1, {32'h00000000, 32'hFFFFFFFF}, 0, 34, 0);

    // Annul ten cycles into the iteration, then restart immediately
    start32 = 1'b1; sd32 = 1'b0; a32 = 32'd1000; b32 = 32'd7;
    repeat (11) @(posedge clk);
    #1; annul32 = 1'b1;
    @(posedge clk); #1; annul32 = 1'b0;
    chk("annul_busy", {63'd0, busy32}, 64'd0);
    chk("annul_ready", {63'd0, rdy32}, 64'd0);
    run(0, 0, 32'd9, 32'd3, {32'h00000000, 32'h00000003}, 0, 34, 0);

    run(1, 0, 32'h0000FFFF, 32'h00000003, {32'd0, 16'h0000, 16'h5555}, 0, 6, 0);

    // Reset pulsed mid-operation aborts at once
    start16 = 1'b1; sd16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0003;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    chk("rst_busy16", {63'd0, busy16}, 64'd0);
    chk("rst_ready16", {63'd0, rdy16}, 64'd0);
    chk("rst_result16", {32'd0, res16}, 64'd0);
    chk("rst_divzero16", {63'd0, dz16}, 64'd0);
    start16 = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    run(1, 0, 32'd100, 32'd7, {32'd0, 16'h0002, 16'h000E}, 0, 6, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(q32.size() + q16.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
